// File: rtl/ow_pkg.sv
// rtl/ow_pkg.sv - 1-Wire command codes, responder states and DS18B20 scratchpad constants.
package ow_pkg;

    localparam logic [7:0] CMD_SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CMD_CONVERT_T    = 8'h44;
    localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;

    // Power-on temperature: 85 degC in 1/16 degC units.
    localparam logic [15:0] TEMP_POR = 16'h0550;

    localparam logic [7:0] SP_BYTE2 = 8'h4B;
    localparam logic [7:0] SP_BYTE3 = 8'h46;
    localparam logic [7:0] SP_BYTE4 = 8'h7F;
    localparam logic [7:0] SP_BYTE5 = 8'hFF;
    localparam logic [7:0] SP_BYTE6 = 8'h0C;
    localparam logic [7:0] SP_BYTE7 = 8'h10;

    typedef enum logic [2:0] {
        IDLE,
        PRES_WAIT,
        PRES,
        ROM_CMD,
        FUNC_CMD,
        CONV_POLL,
        READ_TX
    } ow_state_e;

    function automatic logic [7:0] sp_const_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd2:    b = SP_BYTE2;
            3'd3:    b = SP_BYTE3;
            3'd4:    b = SP_BYTE4;
            3'd5:    b = SP_BYTE5;
            3'd6:    b = SP_BYTE6;
            3'd7:    b = SP_BYTE7;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ow_crc8.sv
// rtl/ow_crc8.sv - serial Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, reflected 0x8C), one bit per enable.
module ow_crc8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       fb;

    always_comb begin
        fb    = crc_q[0] ^ bit_in;
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ds18b20_responder.sv
// rtl/ds18b20_responder.sv - 1-Wire slave emulating a DS18B20: reset/presence, Skip ROM,
// Convert T and Read Scratchpad with a programmable temperature word.
module ds18b20_responder
    import ow_pkg::*;
#(
    parameter int unsigned CLK_MHZ      = 50,
    parameter int unsigned RST_MIN_US   = 480,
    parameter int unsigned PRES_WAIT_US = 30,
    parameter int unsigned PRES_LEN_US  = 120,
    parameter int unsigned SAMPLE_US    = 30,
    parameter int unsigned CONV_US      = 750000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        dq_in,
    output logic        dq_oe,
    input  logic [15:0] temp_in,
    output logic        busy,
    output logic        cmd_done,
    output logic        err
);

    localparam int CNT_W  = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int LOW_W  = $clog2(RST_MIN_US + 1);
    localparam int TMR_W  = $clog2(PRES_WAIT_US + PRES_LEN_US + 1);
    localparam int SLOT_W = $clog2(SAMPLE_US + 1);
    localparam int CONV_W = $clog2(CONV_US + 1);

    ow_state_e          state_q, state_d;
    logic               dq_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LOW_W-1:0]   low_us_q, low_us_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               slot_act_q, slot_act_d;
    logic [SLOT_W-1:0]  slot_us_q, slot_us_d;
    logic [6:0]         sh_q, sh_d;
    logic [7:0]         tx_sh_q, tx_sh_d;
    logic [6:0]         bit_cnt_q, bit_cnt_d;
    logic               busy_q, busy_d;
    logic [CONV_W-1:0]  conv_q, conv_d;
    logic [15:0]        temp_q, temp_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic               fall, rise, tick, bus_rst;
    logic               slot_start, sample, conv_start;
    logic               crc_clr, crc_en;
    logic [7:0]         crc;
    logic [7:0]         rx_byte;
    logic [7:0]         nxt_byte;

    assign fall    = dq_prev_q & ~dq_in;
    assign rise    = ~dq_prev_q & dq_in;
    assign tick    = (cnt_q == CNT_W'(CLK_MHZ - 1));
    assign bus_rst = rise & (low_us_q == LOW_W'(RST_MIN_US));
    assign rx_byte = {dq_in, sh_q};

    // Falls caused by our own pull-down (presence, read-0) never open a slot.
    assign slot_start = fall & ~dq_oe &
                        (state_q inside {ROM_CMD, FUNC_CMD, CONV_POLL, READ_TX});
    assign sample     = slot_act_q & tick & (slot_us_q == SLOT_W'(SAMPLE_US - 1));

    assign dq_oe = (state_q == PRES) |
                   (slot_act_q & (((state_q == CONV_POLL) & busy_q) |
                                  ((state_q == READ_TX) & ~tx_sh_q[0])));

    assign busy     = busy_q;
    assign cmd_done = done_q;
    assign err      = err_q;

    ow_crc8 u_crc (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (tx_sh_q[0]),
        .crc    (crc)
    );

    always_comb begin
        case (bit_cnt_q[6:3])
            4'd0:    nxt_byte = temp_q[7:0];
            4'd1:    nxt_byte = temp_q[15:8];
            4'd8:    nxt_byte = crc;
            default: nxt_byte = sp_const_byte(bit_cnt_q[2:0] == 3'd0 ? bit_cnt_q[5:3] : bit_cnt_q[5:3]);
        endcase
    end

    // Timebase: 1 us tick re-phased on every falling edge; low-time saturates at the reset threshold.
    always_comb begin
        cnt_d    = (fall | tick) ? '0 : cnt_q + CNT_W'(1);
        low_us_d = low_us_q;
        if (fall) begin
            low_us_d = '0;
        end else if (~dq_in & tick & (low_us_q != LOW_W'(RST_MIN_US))) begin
            low_us_d = low_us_q + LOW_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        slot_act_d = slot_act_q;
        slot_us_d  = slot_us_q;
        sh_d       = sh_q;
        tx_sh_d    = tx_sh_q;
        bit_cnt_d  = bit_cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        conv_start = 1'b0;

        if (tick && (state_q inside {PRES_WAIT, PRES})) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        if (slot_act_q && tick) begin
            slot_us_d = slot_us_q + SLOT_W'(1);
        end
        if (slot_start) begin
            slot_act_d = 1'b1;
            slot_us_d  = '0;
            // Bytes are fetched at the first slot of each byte so the CRC is final for byte 8.
            if (state_q == READ_TX && bit_cnt_q[2:0] == 3'd0) begin
                tx_sh_d = nxt_byte;
            end
        end
        if (sample) begin
            slot_act_d = 1'b0;
        end

        case (state_q)
            PRES_WAIT: begin
                if (tick && tmr_q == TMR_W'(PRES_WAIT_US - 1)) begin
                    state_d = PRES;
                    tmr_d   = '0;
                end
            end
            PRES: begin
                if (tick && tmr_q == TMR_W'(PRES_LEN_US - 1)) begin
                    state_d   = ROM_CMD;
                    bit_cnt_d = '0;
                end
            end
            ROM_CMD: begin
                if (sample) begin
                    sh_d      = rx_byte[7:1];
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    if (bit_cnt_q == 7'd7) begin
                        bit_cnt_d = '0;
                        if (rx_byte == CMD_SKIP_ROM) begin
                            state_d = FUNC_CMD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            FUNC_CMD: begin
                if (sample) begin
                    sh_d      = rx_byte[7:1];
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    if (bit_cnt_q == 7'd7) begin
                        bit_cnt_d = '0;
                        if (rx_byte == CMD_CONVERT_T) begin
                            conv_start = 1'b1;
                            state_d    = CONV_POLL;
                        end else if (rx_byte == CMD_READ_SCRATCH) begin
                            tx_sh_d = temp_q[7:0];
                            crc_clr = 1'b1;
                            state_d = READ_TX;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            READ_TX: begin
                if (sample) begin
                    tx_sh_d   = {1'b1, tx_sh_q[7:1]};
                    crc_en    = (bit_cnt_q < 7'd64);
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    if (bit_cnt_q == 7'd71) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: ;
        endcase

        // Bus reset overrides everything except a running conversion.
        if (bus_rst) begin
            state_d    = PRES_WAIT;
            tmr_d      = '0;
            slot_act_d = 1'b0;
            bit_cnt_d  = '0;
            err_d      = 1'b0;
            crc_clr    = 1'b1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        conv_d = conv_q;
        temp_d = temp_q;
        if (conv_start) begin
            busy_d = 1'b1;
            conv_d = '0;
        end else if (busy_q && tick) begin
            if (conv_q == CONV_W'(CONV_US - 1)) begin
                busy_d = 1'b0;
                temp_d = temp_in;
            end else begin
                conv_d = conv_q + CONV_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            dq_prev_q  <= 1'b1;
            cnt_q      <= '0;
            low_us_q   <= '0;
            tmr_q      <= '0;
            slot_act_q <= 1'b0;
            slot_us_q  <= '0;
            sh_q       <= '0;
            tx_sh_q    <= 8'hFF;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            conv_q     <= '0;
            temp_q     <= TEMP_POR;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dq_prev_q  <= dq_in;
            cnt_q      <= cnt_d;
            low_us_q   <= low_us_d;
            tmr_q      <= tmr_d;
            slot_act_q <= slot_act_d;
            slot_us_q  <= slot_us_d;
            sh_q       <= sh_d;
            tx_sh_q    <= tx_sh_d;
            bit_cnt_q  <= bit_cnt_d;
            busy_q     <= busy_d;
            conv_q     <= conv_d;
            temp_q     <= temp_d;
            err_q      <= err_d;
            // Conversion completion pulses cmd_done too.
            done_q     <= done_d | (busy_q & ~busy_d & ~conv_start);
        end
    end

endmodule

// File: tb/tb_ds18b20_responder.sv
// tb/tb_ds18b20_responder.sv - directed 1-Wire master bench for ds18b20_responder.
`timescale 1ns/1ps
module tb_ds18b20_responder;

    localparam int US = 1000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        dq_in;
    logic        dq_oe;
    logic [15:0] temp_in = 16'hABCD;
    logic        busy;
    logic        cmd_done;
    logic        err;

    logic        master_low = 1'b0;
    logic        dq_line;
    logic        sync1 = 1'b1;
    logic        sync2 = 1'b1;

    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    int          oe_cnt = 0;
    realtime     busy_rise_t = 0;
    realtime     busy_fall_t = 0;

    ds18b20_responder #(
        .CLK_MHZ (2),
        .CONV_US (100)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .dq_in     (dq_in),
        .dq_oe     (dq_oe),
        .temp_in   (temp_in),
        .busy      (busy),
        .cmd_done  (cmd_done),
        .err       (err)
    );

    always #250 sys_clk = ~sys_clk;

    assign dq_line = ~(master_low | dq_oe);
    assign dq_in   = sync2;

    always @(posedge sys_clk) begin
        sync1 <= dq_line;
        sync2 <= sync1;
        if (cmd_done) done_cnt <= done_cnt + 1;
        if (dq_oe)    oe_cnt   <= oe_cnt + 1;
    end

    always @(posedge busy) busy_rise_t <= $realtime;
    always @(negedge busy) busy_fall_t <= $realtime;

    function automatic logic [7:0] crc8_model(input logic [63:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [71:0] expected_sp(input logic [15:0] t);
        logic [63:0] d;
        d = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, t[15:8], t[7:0]};
        return {crc8_model(d), d};
    endfunction

    task automatic write_bit(input logic b);
        master_low = 1'b1;
        if (b) begin
            #(5*US);  master_low = 1'b0; #(60*US);
        end else begin
            #(70*US); master_low = 1'b0; #(5*US);
        end
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        master_low = 1'b1;
        #(3*US);
        master_low = 1'b0;
        #(12*US);
        b = dq_line;
        #(50*US);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic bb;
        for (int i = 0; i < 8; i++) begin
            read_bit(bb);
            v[i] = bb;
        end
    endtask

    task automatic ow_reset(output int wait_cyc, output int pres_cyc);
        int n;
        master_low = 1'b1;
        #(500*US);
        master_low = 1'b0;
        n = 0;
        while (dq_in !== 1'b1 && n < 20) begin @(negedge sys_clk); n++; end
        wait_cyc = 0;
        while (dq_oe !== 1'b1 && wait_cyc < 200) begin @(negedge sys_clk); wait_cyc++; end
        pres_cyc = 0;
        while (dq_oe !== 1'b0 && pres_cyc < 400) begin @(negedge sys_clk); pres_cyc++; end
        #(20*US);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (10) @(negedge sys_clk);
        vectors++; if (dq_oe !== 1'b0)    begin miscompares++; $display("FAIL reset dq_oe: got %b expected 0", dq_oe); end
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
        vectors++; if (cmd_done !== 1'b0) begin miscompares++; $display("FAIL reset cmd_done: got %b expected 0", cmd_done); end
        vectors++; if (err !== 1'b0)      begin miscompares++; $display("FAIL reset err: got %b expected 0", err); end
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic test_presence();
        int w, p;
        ow_reset(w, p);
        vectors++;
        if (w < 58 || w > 62) begin miscompares++; $display("FAIL presence delay: got %0d cycles expected 58..62", w); end
        vectors++;
        if (p < 238 || p > 242) begin miscompares++; $display("FAIL presence length: got %0d cycles expected 238..242", p); end
    endtask

    task automatic test_read_default();
        int w, p, d0;
        logic [7:0] v;
        logic [71:0] exp;
        exp = expected_sp(16'h0550);
        d0 = done_cnt;
        ow_reset(w, p);
        write_byte(8'hCC);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL skip_rom err: got %b expected 0", err); end
        write_byte(8'hBE);
        for (int i = 0; i < 9; i++) begin
            read_byte(v);
            vectors++;
            if (v !== exp[i*8 +: 8]) begin
                miscompares++; $display("FAIL read_default byte%0d: got %h expected %h", i, v, exp[i*8 +: 8]);
            end
        end
        vectors++;
        if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL read_default cmd_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_convert();
        int w, p, d0;
        logic b;
        logic [7:0] v;
        logic [71:0] exp;
        realtime dur;
        temp_in = 16'h0191;
        exp = expected_sp(16'h0191);
        ow_reset(w, p);
        write_byte(8'hCC);
        d0 = done_cnt;
        write_byte(8'h44);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL convert busy start: got %b expected 1", busy); end
        read_bit(b);
        vectors++; if (b !== 1'b0) begin miscompares++; $display("FAIL convert poll busy: got %b expected 0", b); end
        read_bit(b);
        vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL convert poll done: got %b expected 1", b); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL convert busy end: got %b expected 0", busy); end
        dur = busy_fall_t - busy_rise_t;
        vectors++;
        if (dur < 99.0*US || dur > 101.0*US) begin miscompares++; $display("FAIL convert busy time: got %0t expected 99..101 us", dur); end
        vectors++;
        if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL convert cmd_done: got %0d pulses expected 1", done_cnt - d0); end
        ow_reset(w, p);
        write_byte(8'hCC);
        write_byte(8'hBE);
        for (int i = 0; i < 9; i++) begin
            read_byte(v);
            vectors++;
            if (v !== exp[i*8 +: 8]) begin
                miscompares++; $display("FAIL convert read byte%0d: got %h expected %h", i, v, exp[i*8 +: 8]);
            end
        end
    endtask

    task automatic test_bad_rom();
        int w, p, oe0;
        logic [7:0] v;
        ow_reset(w, p);
        write_byte(8'h33);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bad_rom err: got %b expected 1", err); end
        oe0 = oe_cnt;
        read_byte(v);
        vectors++; if (v !== 8'hFF) begin miscompares++; $display("FAIL bad_rom idle read: got %h expected ff", v); end
        vectors++; if (oe_cnt !== oe0) begin miscompares++; $display("FAIL bad_rom dq_oe activity: got %0d cycles expected 0", oe_cnt - oe0); end
        ow_reset(w, p);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL bad_rom err cleared: got %b expected 0", err); end
        vectors++;
        if (p < 238 || p > 242) begin miscompares++; $display("FAIL bad_rom presence: got %0d cycles expected 238..242", p); end
    endtask

    task automatic test_abort();
        int w, p, d0;
        logic b;
        logic [19:0] part;
        logic [7:0] v;
        logic [71:0] exp;
        exp = expected_sp(16'h0191);
        d0 = done_cnt;
        ow_reset(w, p);
        write_byte(8'hCC);
        write_byte(8'hBE);
        for (int i = 0; i < 20; i++) begin
            read_bit(b);
            part[i] = b;
        end
        vectors++; if (part !== exp[19:0]) begin miscompares++; $display("FAIL abort partial: got %h expected %h", part, exp[19:0]); end
        ow_reset(w, p);
        vectors++;
        if (p < 238 || p > 242) begin miscompares++; $display("FAIL abort presence: got %0d cycles expected 238..242", p); end
        write_byte(8'hCC);
        write_byte(8'hBE);
        for (int i = 0; i < 9; i++) begin
            read_byte(v);
            vectors++;
            if (v !== exp[i*8 +: 8]) begin
                miscompares++; $display("FAIL abort restart byte%0d: got %h expected %h", i, v, exp[i*8 +: 8]);
            end
        end
        vectors++;
        if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL abort cmd_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    initial begin
        #(40_000*US);
        $display("FAIL watchdog: simulation exceeded 40 ms");
        $fatal(1);
    end

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_presence();
        test_read_default();
        test_convert();
        test_bad_rom();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ds18b20_responder.md
Name: ds18b20_responder

Overview:
- Synthesizable 1-Wire slave that emulates a DS18B20 temperature sensor. It is the other end of the single-bus protocol driven by the temp_disp master.
- Used for FPGA loopback and bench closure of the temperature path: a second FPGA pin (or the testbench) drives dq, and the responder supplies a programmable temperature word.
- Supports bus reset/presence, Skip ROM (0xCC), Convert T (0x44) and Read Scratchpad (0xBE) with a 9-byte scratchpad and Dallas CRC-8.

Parameters:
- CLK_MHZ, 50, system clock frequency in MHz; sets the 1 us tick divider.
- RST_MIN_US, 480, minimum dq low time recognised as a bus reset.
- PRES_WAIT_US, 30, delay from reset release to presence pulse start.
- PRES_LEN_US, 120, presence pulse length.
- SAMPLE_US, 30, sample point / read-0 hold time measured from slot falling edge.
- CONV_US, 750000, Convert T busy time.

Ports:
- sys_clk  input  1  system clock.
- sys_rst_n  input  1  reset; synchronous, active-low.
- dq_in  input  1  bus level, already 2-flop synchronised externally.
- dq_oe  output  1  1 = pull dq low (open-drain enable); top ties dq = dq_oe ? 1'b0 : 1'bz.
- temp_in  input  16  temperature word (DS18B20 format, 1/16 degC), latched at Convert T completion.
- busy  output  1  high during conversion.
- cmd_done  output  1  one-cycle pulse after the last bit of a completed 0x44 or 0xBE transaction.
- err  output  1  sticky until next bus reset; set on an unsupported ROM or function command.

Behaviour:
- All state changes occur on posedge sys_clk.
- While sys_rst_n = 0:
  - dq_oe = 0, busy = 0, cmd_done = 0, err = 0.
  - Scratchpad temperature = 16'h0550 (85 degC, the power-on value).
  - State = IDLE.
- Timebase: free-running tick counter (CLK_MHZ cycles = 1 us). It is restarted on every dq_in falling edge so slot timing is edge-aligned. The low-time counter saturates at RST_MIN_US.
- Bus reset detection has priority in every state:
  - A dq_in low period >= RST_MIN_US, followed by its rising edge, moves to PRES_WAIT.
  - Any transfer in progress is aborted, bit/byte counters are cleared, and err is cleared.
  - A conversion in progress continues.
- States:
  - IDLE: ignore slots; wait for reset.
  - PRES_WAIT: wait PRES_WAIT_US, then go to PRES.
  - PRES: dq_oe = 1 for PRES_LEN_US, then release and go to ROM_CMD.
  - ROM_CMD:
    - Receive 8 bits, LSB first. Each slot starts at a dq_in falling edge; bit = dq_in sampled SAMPLE_US later.
    - 0xCC goes to FUNC_CMD. Any other value sets err and goes to IDLE.
  - FUNC_CMD: receive 8 bits the same way.
    - 0x44: start conversion; go to CONV_POLL.
    - 0xBE: load the shift register with byte 0; go to READ_TX.
    - Other: set err; go to IDLE.
  - CONV_POLL: each read slot returns 0 (dq_oe = 1 from falling edge for SAMPLE_US) while busy, 1 (no drive) once done. Stays here until the next reset.
  - READ_TX: transmit 72 bits, LSB first, byte 0 to byte 8.
    - Per slot: bit 0 means dq_oe = 1 from the cycle after the falling edge for SAMPLE_US; bit 1 means no drive.
    - After bit 71: cmd_done pulse, go to IDLE.
    - Read slots beyond 72 return 1.
- Conversion:
  - busy rises in the cycle after the 0x44 command bit 7 sample.
  - After CONV_US, temp_in is latched into scratchpad bytes 0/1, busy falls, and cmd_done pulses.
- Scratchpad, bytes 0 to 8:
  - Byte 0: temp[7:0].
  - Byte 1: temp[15:8].
  - Bytes 2 to 7: 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10.
  - Byte 8: CRC-8 (polynomial x^8+x^5+x^4+1, reflected 0x8C, init 0x00) over bytes 0 to 7. Computed serially during transmission of bytes 0 to 7, so byte 8 is ready at bit 64.
- Edge cases:
  - A falling edge while dq_oe = 1 (own drive) is not a new slot.
  - Slots in IDLE are ignored.
  - A reset during PRES (low held by master beyond the pulse) is handled as a new reset.
  - 0xBE during busy returns the previous temperature.

Decomposition:
- Package ow_pkg: 1-Wire command constants (CMD_SKIP_ROM, CMD_CONVERT_T, CMD_READ_SCRATCH), the state enum, and the default scratchpad constant bytes.
- Sub-module ow_crc8: serial Dallas CRC-8, with ports clr, en, bit_in, crc[7:0]. Shared later with temp_disp for checking.

Test Plan:
- Master holds dq low 500 us, then releases -> dq_oe rises 30 us (+/-1 us) after release and stays high 120 us.
- Reset, 0xCC, 0xBE straight after sys_rst_n -> bytes 50 05 4B 46 7F FF 0C 10 + CRC; byte 8 matches the bench CRC-8 model; cmd_done pulses once.
- temp_in = 16'h0191 with CONV_US = 100, then reset/0xCC/0x44 -> busy high 100 us; reads return 0 then 1; a following 0xBE returns 91 01 ...
- ROM command 0x33 -> err = 1, no further dq_oe activity; the next reset clears err and gives a presence pulse.
- Reset pulse issued after 20 bits of a 0xBE transfer -> presence pulse; the new 0xBE sequence restarts at byte 0 bit 0.
- Write slots of 5 us low (bit 1) and 70 us low (bit 0) at the sample edge -> correct decode of 0xCC.
